// File: rtl/matvec_seq_ctrl_if.sv
// Element-memory read port and result stream port
// of the sequential matrix-vector engine.
interface matvec_seq_ctrl_if #(
  parameter int DATA_SIZE = 16,
  parameter int ROW_AW    = 6,
  parameter int COL_AW    = 6
);
  logic                     mem_req;
  logic [ROW_AW+COL_AW-1:0] mem_addr;
  logic                     mem_rvalid;
  logic [DATA_SIZE-1:0]     mem_rdata;
  logic                     res_valid;
  logic                     res_ready;
  logic [DATA_SIZE-1:0]     res_data;
  logic [ROW_AW-1:0]        res_row;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rvalid,
    input  mem_rdata,
    output res_valid,
    output res_data,
    output res_row,
    input  res_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rvalid,
    output mem_rdata,
    input  res_valid,
    input  res_data,
    input  res_row,
    output res_ready
  );
endinterface

// File: rtl/matvec_seq_ctrl.sv
// Single-lane sequencer for B*A in Q0.DATA_SIZE:
// one MAC per accepted element, one saturated result per row.
module matvec_seq_ctrl #(
  parameter int DATA_SIZE   = 16,
  parameter int COLUMN_SIZE = 64,
  parameter int ROW_SIZE    = 64,
  parameter int COL_AW      = 6,
  parameter int ROW_AW      = 6
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             clear,
  input  logic [DATA_SIZE*COLUMN_SIZE-1:0] vecA,
  matvec_seq_ctrl_if.master                bus,
  output logic                             busy,
  output logic                             done
);

  localparam int ACC_SIZE = DATA_SIZE + DATA_SIZE/2 + 1;
  localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(COLUMN_SIZE-1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROW_SIZE-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_OUT,
    S_DONE
  } state_e;

  typedef logic [COLUMN_SIZE-1:0][DATA_SIZE-1:0] vec_t;

  state_e              state_q, state_d;
  logic [ROW_AW-1:0]   row_q, row_d;
  logic [COL_AW-1:0]   col_q, col_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  vec_t                vec_q, vec_d;

  logic [2*DATA_SIZE-1:0] prod;
  logic [DATA_SIZE-1:0]   sat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
    end
  end

  // Upper half of the Q0 product is the truncated term
  assign prod = vec_q[col_q] * bus.mem_rdata;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = vec_t'(vecA);
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.mem_rvalid) begin
          acc_d = acc_q + ACC_SIZE'(prod >> DATA_SIZE);
          if (col_q == COL_LAST)
            state_d = S_OUT;
          else
            col_d = col_q + 1'b1;
        end
      end
      S_OUT: begin
        if (bus.res_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            acc_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear)
      state_d = S_IDLE;
  end

  assign sat = (|acc_q[ACC_SIZE-1:DATA_SIZE]) ?
               '1 : acc_q[DATA_SIZE-1:0];

  assign bus.mem_req   = (state_q == S_FETCH);
  assign bus.mem_addr  = {row_q, col_q};
  assign bus.res_valid = (state_q == S_OUT);
  assign bus.res_data  = bus.res_valid ? sat : '0;
  assign bus.res_row   = bus.res_valid ? row_q : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Bench for matvec_seq_ctrl: memory/consumer models plus
// an arithmetic reference of each saturated row product.
module tb_matvec_seq_ctrl;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          clear;
  logic [1023:0] vecA;
  logic          busy;
  logic          done;

  matvec_seq_ctrl_if bus ();

  matvec_seq_ctrl dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .clear (clear),
    .vecA  (vecA),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  int unsigned A [64];
  logic [15:0] Bm [64][64];

  assign bus.mem_rdata = Bm[bus.mem_addr[11:6]][bus.mem_addr[5:0]];

  int checks = 0;
  int errors = 0;

  bit          rv_rand = 0;
  bit          chk_en = 0;
  int          stall_row = -1;
  int          hold_cnt = 0;
  int          done_cnt = 0;
  logic [21:0] held;
  bit          prev_stall = 0;
  logic [11:0] prev_addr;
  bit          ready_n;
  int          q_row [$];
  logic [15:0] q_data [$];
  logic [15:0] got [64];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_row(input int r);
    longint unsigned sum = 0;
    for (int c = 0; c < 64; c++)
      sum += (longint'(A[c]) * longint'(Bm[r][c])) >> 16;
    return (sum > 64'hFFFF) ? 16'hFFFF : sum[15:0];
  endfunction

  // Memory/consumer side, decided away from the active edge
  always @(negedge clock) begin
    if (chk_en && prev_stall) begin
      chk("addr_hold", bus.mem_addr, prev_addr);
      chk("req_hold", bus.mem_req, 1);
    end
    if (done) done_cnt++;
    ready_n = 1'b1;
    if (bus.res_valid && int'(bus.res_row) == stall_row
        && hold_cnt < 10) begin
      ready_n = 1'b0;
      if (hold_cnt > 0)
        chk("stall_hold", {bus.res_row, bus.res_data}, held);
      chk("stall_req", bus.mem_req, 0);
      held = {bus.res_row, bus.res_data};
      hold_cnt++;
    end
    bus.res_ready  = ready_n;
    bus.mem_rvalid = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (bus.res_valid && ready_n) begin
      q_row.push_back(int'(bus.res_row));
      q_data.push_back(bus.res_data);
    end
    prev_stall = bus.mem_req && !bus.mem_rvalid;
    prev_addr  = bus.mem_addr;
  end

  task automatic pack_a();
    for (int c = 0; c < 64; c++)
      vecA[c*16 +: 16] = A[c][15:0];
  endtask

  task automatic set_t2();
    for (int c = 0; c < 64; c++) A[c] = (c == 0) ? 32'hFFFF : 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        Bm[r][c] = (c == 0) ? 16'(r * 32'h100) : 16'h0;
  endtask

  task automatic do_run(input bit rr, input int srow,
                        input bit poke, input int exp_first);
    int cyc;
    int first;
    rv_rand = rr;
    stall_row = srow;
    hold_cnt = 0;
    done_cnt = 0;
    q_row.delete();
    q_data.delete();
    chk_en = 1;
    pack_a();
    start = 1;
    @(negedge clock);
    start = 0;
    vecA = {32{$urandom()}};
    cyc = 1;
    first = -1;
    while (busy && cyc < 20000) begin
      if (bus.res_valid && first < 0) first = cyc;
      if (poke) start = (cyc == 300);
      @(negedge clock);
      cyc++;
    end
    start = 0;
    chk("run_timeout", cyc < 20000, 1);
    if (exp_first >= 0) chk("first_valid", first, exp_first);
    chk("done_pulses", done_cnt, 1);
    chk("n_results", q_row.size(), 64);
    for (int i = 0; i < q_row.size() && i < 64; i++) begin
      chk("res_row", q_row[i], i);
      chk("res_data", q_data[i], ref_row(i));
      got[i] = q_data[i];
    end
  endtask

  initial begin
    int cyc;
    reset = 0;
    start = 0;
    clear = 0;
    vecA = '0;
    bus.res_ready = 1;
    bus.mem_rvalid = 1;
    repeat (2) @(negedge clock);
    chk("reset_outs", {busy, done, bus.mem_req, bus.mem_addr,
        bus.res_valid, bus.res_data, bus.res_row}, 0);
    reset = 1;
    @(negedge clock);

    // T1: saturation on every row
    for (int c = 0; c < 64; c++) A[c] = 32'h8000;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) Bm[r][c] = 16'h8000;
    do_run(0, -1, 0, 65);
    chk("t1_row0", got[0], 16'hFFFF);

    // T2 / T3: single-column product, then consumer stall
    set_t2();
    do_run(0, -1, 0, 65);
    chk("t2_row0", got[0], 16'h0000);
    chk("t2_row63", got[63], 16'h3EFF);
    do_run(0, 5, 0, 65);
    chk("t3_row5", got[5], 16'h04FF);
    chk("t3_stalls", hold_cnt, 10);

    // T4: random memory stalls
    do_run(1, -1, 0, -1);

    // Random data, stalls both sides, start poked mid-run
    for (int c = 0; c < 64; c++) A[c] = $urandom_range(0, 16'hFFFF);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        Bm[r][c] = 16'($urandom_range(0, 16'h07FF));
    do_run(1, 7, 1, -1);

    // T5: clear at row 20, col 7
    set_t2();
    rv_rand = 0;
    stall_row = -1;
    done_cnt = 0;
    chk_en = 0;
    pack_a();
    start = 1;
    @(negedge clock);
    start = 0;
    cyc = 0;
    while (!(bus.mem_req && bus.mem_addr == {6'd20, 6'd7})
           && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    chk("clear_reach", cyc < 5000, 1);
    clear = 1;
    @(negedge clock);
    clear = 0;
    chk("clear_outs",
        {busy, bus.mem_req, bus.res_valid, done}, 0);
    repeat (3) @(negedge clock);
    chk("clear_nodone", done_cnt, 0);
    chk("clear_idle", busy, 0);
    do_run(0, -1, 0, 65);

    // Asynchronous reset mid-row
    chk_en = 0;
    pack_a();
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (100) @(negedge clock);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 0;
    #1 chk("async_reset_outs", {busy, done, bus.mem_req,
        bus.mem_addr, bus.res_valid, bus.res_data,
        bus.res_row}, 0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    do_run(1, -1, 0, -1);

    // T6: start and clear together in IDLE
    start = 1;
    clear = 1;
    @(negedge clock);
    start = 0;
    clear = 0;
    chk("start_clear_busy", busy, 0);
    chk("start_clear_req", bus.mem_req, 0);
    @(negedge clock);
    chk("start_clear_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
